// File: rtl/gray2rgb_pkg.sv
// Shared types for the gray-to-RGB pixel converter: per-beat mode select and
// heatmap segment encodings (segment = top two bits of the gray sample).
package gray2rgb_pkg;

    typedef enum logic [1:0] {
        MODE_REPLICATE     = 2'd0,
        MODE_THRESH        = 2'd1,
        MODE_HEATMAP       = 2'd2,
        MODE_REPLICATE_ALT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        SEG_BLUE_CYAN    = 2'd0,
        SEG_CYAN_GREEN   = 2'd1,
        SEG_GREEN_YELLOW = 2'd2,
        SEG_YELLOW_RED   = 2'd3
    } seg_e;

endpackage

// File: rtl/gray2rgb_elastic.sv
// One elastic pipeline register: a single data slot with valid/ready on both
// sides. Only the valid bit is reset; the data slot loads on every accepted beat.
module gray2rgb_elastic #(
    parameter int WIDTH_P = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH_P-1:0] data_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH_P-1:0] data_o
);

    logic               valid_q;
    logic [WIDTH_P-1:0] data_q;

    // Accept whenever the slot is empty or its occupant leaves this same cycle.
    assign ready_o = ~valid_q | ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else if (ready_o) begin
            valid_q <= valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (valid_i && ready_o) begin
            data_q <= data_i;
        end
    end

endmodule

// File: rtl/gray2rgb.sv
// Two-stage elastic gray-to-RGB converter (replicate / threshold / heatmap).
// Heatmap colouring is built only when GRAY2RGB_HEATMAP_EN is defined; otherwise mode 2 replicates.
module gray2rgb
    import gray2rgb_pkg::*;
#(
    parameter int WIDTH_P = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH_P-1:0] gray_i,
    input  logic [1:0]         mode_i,
    input  logic [WIDTH_P-1:0] thresh_i,
    input  logic               last_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH_P-1:0] red_o,
    output logic [WIDTH_P-1:0] green_o,
    output logic [WIDTH_P-1:0] blue_o,
    output logic               last_o
);

    // Handshake: a beat moves across any port exactly in a cycle where valid and
    // ready are both high; valid never waits on ready, and a held beat is stable.
    localparam logic [WIDTH_P-1:0] MAX = '1;
`ifdef GRAY2RGB_HEATMAP_EN
    localparam int S1_W = 2 * WIDTH_P + 6;
`else
    localparam int S1_W = WIDTH_P + 4;
`endif
    localparam int S2_W = 3 * WIDTH_P + 1;

    logic [S1_W-1:0]    s1_d, s1_q;
    logic [S2_W-1:0]    s2_d, s2_q;
    logic               s1_valid, s2_ready;

    mode_e              s1_mode;
    logic               s1_last, s1_ge;
    logic [WIDTH_P-1:0] s1_gray;
    logic [WIDTH_P-1:0] red, green, blue;

    // Stage-1 layout, MSB first: mode, last, compare, gray [, seg, ramp].
`ifdef GRAY2RGB_HEATMAP_EN
    seg_e               s1_seg;
    logic [WIDTH_P-1:0] s1_ramp;

    assign s1_d = {mode_i, last_i, (gray_i >= thresh_i), gray_i,
                   gray_i[WIDTH_P-1:WIDTH_P-2],
                   gray_i[WIDTH_P-3:0], gray_i[WIDTH_P-3:WIDTH_P-4]};
    assign s1_seg  = seg_e'(s1_q[WIDTH_P+1 -: 2]);
    assign s1_ramp = s1_q[WIDTH_P-1:0];
`else
    assign s1_d = {mode_i, last_i, (gray_i >= thresh_i), gray_i};
`endif

    assign s1_mode = mode_e'(s1_q[S1_W-1 -: 2]);
    assign s1_last = s1_q[S1_W-3];
    assign s1_ge   = s1_q[S1_W-4];
    assign s1_gray = s1_q[S1_W-5 -: WIDTH_P];

    always_comb begin
        red   = s1_gray;
        green = s1_gray;
        blue  = s1_gray;
        case (s1_mode)
            MODE_THRESH: begin
                red   = s1_ge ? MAX : '0;
                green = s1_ge ? MAX : '0;
                blue  = s1_ge ? MAX : '0;
            end
`ifdef GRAY2RGB_HEATMAP_EN
            MODE_HEATMAP: begin
                case (s1_seg)
                    SEG_BLUE_CYAN:    begin red = '0;      green = s1_ramp;       blue = MAX;           end
                    SEG_CYAN_GREEN:   begin red = '0;      green = MAX;           blue = MAX - s1_ramp; end
                    SEG_GREEN_YELLOW: begin red = s1_ramp; green = MAX;           blue = '0;            end
                    default:          begin red = MAX;     green = MAX - s1_ramp; blue = '0;            end
                endcase
            end
`endif
            default: ;
        endcase
    end

    assign s2_d = {s1_last, red, green, blue};
    assign {last_o, red_o, green_o, blue_o} = s2_q;

    gray2rgb_elastic #(.WIDTH_P(S1_W)) u_s1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (s1_d),
        .valid_o (s1_valid),
        .ready_i (s2_ready),
        .data_o  (s1_q)
    );

    gray2rgb_elastic #(.WIDTH_P(S2_W)) u_s2 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (s1_valid),
        .ready_o (s2_ready),
        .data_i  (s2_d),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (s2_q)
    );

endmodule

// File: tb/tb_gray2rgb.sv
// Directed bench for gray2rgb: latency, mode vectors, randomised backpressure
// stream and mid-stream reset, checked against an expected-pixel queue.
module tb_gray2rgb;

    localparam int W  = 8;
    localparam int OW = 3 * W + 1;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] gray_i = '0;
    logic [1:0]   mode_i = '0;
    logic [W-1:0] thresh_i = '0;
    logic         last_i = 1'b0;
    logic         valid_o;
    logic         ready_i = 1'b1;
    logic [W-1:0] red_o, green_o, blue_o;
    logic         last_o;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    gray2rgb #(.WIDTH_P(W)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .gray_i   (gray_i),
        .mode_i   (mode_i),
        .thresh_i (thresh_i),
        .last_i   (last_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .red_o    (red_o),
        .green_o  (green_o),
        .blue_o   (blue_o),
        .last_o   (last_o)
    );

    // ---------------- scoreboard state ----------------
    logic [OW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_pass = 0;
    int            n_pop = 0;
    logic          hold_pending = 1'b0;
    logic [OW-1:0] held = '0;
    logic          in_acc, out_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [OW-1:0] px(input logic l, input logic [W-1:0] r,
                                         input logic [W-1:0] g, input logic [W-1:0] b);
        return {l, r, g, b};
    endfunction

    // ---------------- driver: one cycle, inputs and sampling at negedge ----------------
    task automatic run_cycle(input logic v, input logic [W-1:0] g, input logic [1:0] m,
                             input logic [W-1:0] t, input logic l, input logic r,
                             input logic [OW-1:0] e);
        logic [OW-1:0] out;
        @(negedge clk);
        valid_i = v; gray_i = g; mode_i = m; thresh_i = t; last_i = l; ready_i = r;
        #1;
        out = {last_o, red_o, green_o, blue_o};
        if (hold_pending) begin
            check("hold_valid", valid_o, 1);
            if (valid_o) check("hold_data", out, held);
        end
        check("ready_o", ready_o, !(exp_q.size() == 2 && !r));
        hold_pending = valid_o && !r;
        held = out;
        in_acc = v && ready_o;
        out_acc = valid_o && r;
        if (out_acc) begin
            if (exp_q.size() == 0) check("extra_beat", valid_o, 0);
            else begin
                check("pixel", out, exp_q.pop_front());
                n_pop++;
            end
        end
        if (in_acc) exp_q.push_back(e);
    endtask

    task automatic idle(input logic r);
        run_cycle(1'b0, '0, 2'd0, '0, 1'b0, r, '0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        repeat (n) @(negedge clk);
        rst_i = 1'b0;
        exp_q.delete();
        hold_pending = 1'b0;
        #1;
        check("rst_valid_o", valid_o, 0);
        check("rst_ready_o", ready_o, 1);
    endtask

    task automatic send_one(input string tag, input logic [W-1:0] g, input logic [1:0] m,
                            input logic [W-1:0] t, input logic [OW-1:0] e);
        run_cycle(1'b1, g, m, t, 1'b0, 1'b1, e);
        check({tag, "_accept"}, in_acc, 1);
        idle(1'b1);
        check({tag, "_lat1"}, valid_o, 0);
        idle(1'b1);
        check({tag, "_lat2"}, valid_o, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sent, pop0;
        logic [W-1:0] g;
        logic [W-1:0] c;
        logic [1:0] m;
        logic l;

        do_reset(2);

        send_one("rep_5a", 8'h5A, 2'd0, 8'h00, px(1'b0, 8'h5A, 8'h5A, 8'h5A));
        send_one("rep_m3", 8'h33, 2'd3, 8'hFF, px(1'b0, 8'h33, 8'h33, 8'h33));
        send_one("thr_eq", 8'h80, 2'd1, 8'h80, px(1'b0, 8'hFF, 8'hFF, 8'hFF));
        send_one("thr_lo", 8'h7F, 2'd1, 8'h80, px(1'b0, 8'h00, 8'h00, 8'h00));
        send_one("thr_z",  8'h00, 2'd1, 8'h00, px(1'b0, 8'hFF, 8'hFF, 8'hFF));
`ifdef GRAY2RGB_HEATMAP_EN
        send_one("heat_00", 8'h00, 2'd2, 8'h00, px(1'b0, 8'h00, 8'h00, 8'hFF));
        send_one("heat_40", 8'h40, 2'd2, 8'h00, px(1'b0, 8'h00, 8'hFF, 8'hFF));
        send_one("heat_50", 8'h50, 2'd2, 8'h00, px(1'b0, 8'h00, 8'hFF, 8'hBE));
        send_one("heat_80", 8'h80, 2'd2, 8'h00, px(1'b0, 8'h00, 8'hFF, 8'h00));
        send_one("heat_ff", 8'hFF, 2'd2, 8'h00, px(1'b0, 8'hFF, 8'h00, 8'h00));
`else
        send_one("heat_off_80", 8'h80, 2'd2, 8'h00, px(1'b0, 8'h80, 8'h80, 8'h80));
        send_one("heat_off_40", 8'h40, 2'd2, 8'h00, px(1'b0, 8'h40, 8'h40, 8'h40));
`endif

        // 16-beat stream: even beats replicate, odd beats threshold at 0x80.
        sent = 0;
        pop0 = n_pop;
        for (int cyc = 0; cyc < 400 && (n_pop - pop0) < 16; cyc++) begin
            g = W'(sent * 17);
            m = 2'(sent % 2);
            l = (sent % 4) == 3;
            c = (m == 2'd0) ? g : ((g >= 8'h80) ? 8'hFF : 8'h00);
            run_cycle((sent < 16) && ($urandom_range(0, 3) != 0), g, m, 8'h80, l,
                      1'($urandom_range(0, 1)), px(l, c, c, c));
            if (in_acc) sent++;
        end
        check("stream_sent", sent, 16);
        check("stream_recv", n_pop - pop0, 16);

        // Fill both stages under backpressure, then reset.
        run_cycle(1'b1, 8'hA1, 2'd0, '0, 1'b1, 1'b0, px(1'b1, 8'hA1, 8'hA1, 8'hA1));
        check("fill1_accept", in_acc, 1);
        run_cycle(1'b1, 8'hB2, 2'd0, '0, 1'b0, 1'b0, px(1'b0, 8'hB2, 8'hB2, 8'hB2));
        check("fill2_accept", in_acc, 1);
        run_cycle(1'b1, 8'hC3, 2'd0, '0, 1'b0, 1'b0, px(1'b0, 8'hC3, 8'hC3, 8'hC3));
        check("full_ready_o", ready_o, 0);
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            check("no_stale", valid_o, 0);
        end

        send_one("post_rst", 8'h3C, 2'd0, 8'h00, px(1'b0, 8'h3C, 8'h3C, 8'h3C));
        idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
